lcd_fb_fill_ctrl: RTL and testbench

LCD_FB_FILL_CTRL -- requirements
Module: lcd_fb_fill_ctrl

---
 rtl/lcd_fb_fill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lcd_fb_fill_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_fill_ctrl.sv
// ============================================================================
//  lcd_fb_fill_ctrl : rectangle-fill engine with CPU pixel-write priority
//                     into a 5-bank 1-bpp LCD frame buffer.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_fb_fill_ctrl #(
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [8:0] cmd_x,
   input  logic [7:0] cmd_y,
   input  logic [8:0] cmd_w,
   input  logic [7:0] cmd_h,
   input  logic       cmd_color,
   input  logic       cpu_wr,
   input  logic [8:0] cpu_x,
   input  logic [7:0] cpu_y,
   input  logic       cpu_color,
   output logic [4:0] fb_we,
   output logic [13:0] fb_addr,
   output logic       fb_data,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [16:0] C_H_STEP = 17'(H_RES);
   localparam logic [9:0]  C_H_LIM  = 10'(H_RES);
   localparam logic [8:0]  C_V_LIM  = 9'(V_RES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // y*H_RES+x built from shifted copies of y selected by the constant's set bits
   function automatic logic [16:0] pix_index(input logic [8:0] x, input logic [7:0] y);
      logic [16:0] acc;
      acc = {8'd0, x};
      for (int i = 0; i < 17; i++) begin
         if (C_H_STEP[i]) acc = acc + ({9'd0, y} << i);
      end
      return acc;
   endfunction

   state_t      state_q, state_d;
   logic [8:0]  x_q, x_d, w_q, w_d, col_q, col_d;
   logic [7:0]  y_q, y_d, h_q, h_d, row_q, row_d;
   logic        color_q, color_d, err_q, err_d;
   logic [16:0] row_base_q, row_base_d;
   logic [4:0]  fb_we_q, fb_we_d;
   logic [13:0] fb_addr_q, fb_addr_d;
   logic        fb_data_q, fb_data_d;

   logic        w_cpu_ok;
   logic        w_bad_cmd;
   logic        w_wr_en;
   logic [16:0] w_wr_idx;
   logic        w_wr_data;

   assign w_cpu_ok  = cpu_wr && ({1'b0, cpu_x} < C_H_LIM) && ({1'b0, cpu_y} < C_V_LIM);
   assign w_bad_cmd = (w_q == 9'd0) || (h_q == 8'd0) ||
                      (({1'b0, x_q} + {1'b0, w_q}) > C_H_LIM) ||
                      (({1'b0, y_q} + {1'b0, h_q}) > C_V_LIM);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      w_d        = w_q;
      h_d        = h_q;
      color_d    = color_q;
      err_d      = err_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      w_wr_en    = 1'b0;
      w_wr_idx   = '0;
      w_wr_data  = 1'b0;

      if (w_cpu_ok) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = pix_index(cpu_x, cpu_y);
         w_wr_data = cpu_color;
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               x_d     = cmd_x;
               y_d     = cmd_y;
               w_d     = cmd_w;
               h_d     = cmd_h;
               color_d = cmd_color;
               err_d   = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (w_bad_cmd) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               row_base_d = pix_index(x_q, y_q);
               col_d      = '0;
               row_d      = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            // A CPU write owns this cycle; fill counters stay frozen
            if (!w_cpu_ok) begin
               w_wr_en   = 1'b1;
               w_wr_idx  = row_base_q + {8'd0, col_q};
               w_wr_data = color_q;
               if (col_q == w_q - 9'd1) begin
                  col_d      = '0;
                  row_d      = row_q + 8'd1;
                  row_base_d = row_base_q + C_H_STEP;
                  if (row_q == h_q - 8'd1) state_d = DONE;
               end else begin
                  col_d = col_q + 9'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      fb_we_d   = w_wr_en ? (5'd1 << w_wr_idx[16:14]) : 5'd0;
      fb_addr_d = w_wr_en ? w_wr_idx[13:0] : fb_addr_q;
      fb_data_d = w_wr_en ? w_wr_data : fb_data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= 1'b0;
         err_q      <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         fb_we_q    <= '0;
         fb_addr_q  <= '0;
         fb_data_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         w_q        <= w_d;
         h_q        <= h_d;
         color_q    <= color_d;
         err_q      <= err_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign fb_we     = fb_we_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_fb_fill_ctrl.sv
// ============================================================================
//  tb_lcd_fb_fill_ctrl : scoreboard bench for lcd_fb_fill_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_fb_fill_ctrl;

   localparam int H = 320;
   localparam int V = 240;

   typedef struct packed {
      logic [2:0]  bank;
      logic [13:0] addr;
      logic        data;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [8:0] cmd_x = '0;
   logic [7:0] cmd_y = '0;
   logic [8:0] cmd_w = '0;
   logic [7:0] cmd_h = '0;
   logic       cmd_color = 1'b0;
   logic       cpu_wr = 1'b0;
   logic [8:0] cpu_x = '0;
   logic [7:0] cpu_y = '0;
   logic       cpu_color = 1'b0;
   logic [4:0] fb_we;
   logic [13:0] fb_addr;
   logic       fb_data;
   logic       busy, done, err;

   lcd_fb_fill_ctrl #(.H_RES(H), .V_RES(V)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
      .cpu_wr(cpu_wr), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_color(cpu_color),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   wr_t fill_q[$];
   wr_t cpu_q[$];
   bit  done_q[$];
   bit  cpu_exp_now = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic chk_wr(input string name, input wr_t e);
      logic [4:0] exp_we;
      exp_we = 5'd1 << e.bank;
      chk(name, {12'd0, fb_we, fb_addr, fb_data}, {12'd0, exp_we, e.addr, e.data});
   endtask

   // Monitor: a legal CPU write presented at an edge must be the next output
   always @(posedge clk) cpu_exp_now <= reset && cpu_wr && (int'(cpu_x) < H) && (int'(cpu_y) < V);

   always @(negedge clk) begin
      wr_t e;
      if (fb_we != 5'd0) chk("we_onehot", 32'($onehot(fb_we)), 32'd1);
      if (cpu_exp_now) begin
         if (cpu_q.size() == 0) fail("cpu_q_underflow");
         else begin
            e = cpu_q.pop_front();
            chk_wr("cpu_write", e);
         end
      end else if (fb_we != 5'd0) begin
         if (fill_q.size() == 0) fail("unexpected_write");
         else begin
            e = fill_q.pop_front();
            chk_wr("fill_write", e);
         end
      end
      if (done) begin
         if (done_q.size() == 0) fail("unexpected_done");
         else begin
            chk("done_err", {31'd0, err}, {31'd0, done_q.pop_front()});
            chk("fill_count_at_done", fill_q.size(), 0);
         end
      end
   end

   // Reference model: the rectangle expanded pixel by pixel in raster order
   task automatic model_push(input int x, input int y, input int w, input int h, input bit c);
      bit  e;
      int  idx;
      wr_t t;
      e = (w == 0) || (h == 0) || (x + w > H) || (y + h > V);
      done_q.push_back(e);
      if (!e) begin
         for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
               idx    = (y + r) * H + (x + k);
               t.bank = 3'(idx / 16384);
               t.addr = 14'(idx % 16384);
               t.data = c;
               fill_q.push_back(t);
            end
         end
      end
   endtask

   int acc_cyc;

   task automatic send_cmd(input int x, input int y, input int w, input int h, input bit c);
      int n;
      cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = c;
      cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         fail("cmd_accept_timeout");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
      model_push(x, y, w, h, c);
   endtask

   task automatic drive_cpu(input int x, input int y, input bit c);
      wr_t t;
      int  idx;
      cpu_wr = 1'b1; cpu_x = 9'(x); cpu_y = 8'(y); cpu_color = c;
      if (x < H && y < V) begin
         idx    = y * H + x;
         t.bank = 3'(idx / 16384);
         t.addr = 14'(idx % 16384);
         t.data = c;
         cpu_q.push_back(t);
      end
   endtask

   // Runs until the engine is idle, injecting random CPU writes at pct percent
   task automatic run_cpu(input int pct);
      int n;
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         #1;
         cpu_wr = 1'b0;
         if (!busy) break;
         if (int'($urandom_range(99)) < pct)
            drive_cpu(int'($urandom_range(339)), int'($urandom_range(255)), 1'($urandom));
         n++;
      end
      cpu_wr = 1'b0;
      if (n >= 3000) fail("busy_timeout");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x, y, w, h;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Basic 4x2 fill with latency of the first write
      send_cmd(0, 0, 4, 2, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("setup_no_write", fb_we, 0);
      @(negedge clk);
      chk("first_write_latency", {fb_we, fb_addr}, {5'b00001, 14'd0});
      run_cpu(0);

      // Last pixel of the screen, bank 4
      send_cmd(319, 239, 1, 1, 1'b1);
      run_cpu(0);

      // Rejected commands and the largest legal neighbour
      send_cmd(300, 0, 21, 1, 1'b1);
      run_cpu(0);
      chk("err_held", err, 1);
      send_cmd(5, 5, 0, 3, 1'b1);
      run_cpu(0);
      send_cmd(5, 5, 3, 0, 1'b1);
      run_cpu(0);
      send_cmd(10, 230, 2, 11, 1'b0);
      run_cpu(0);
      send_cmd(300, 0, 20, 1, 1'b1);
      run_cpu(0);
      chk("err_cleared", err, 0);

      // Bank boundary crossing
      send_cmd(63, 51, 2, 1, 1'b1);
      run_cpu(0);

      // CPU write during the third fill cycle
      send_cmd(0, 0, 4, 2, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      drive_cpu(10, 1, 1'b0);
      @(posedge clk); #1;
      cpu_wr = 1'b0;
      run_cpu(0);

      // Out-of-range CPU write during a fill must not stall it
      send_cmd(100, 100, 6, 2, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive_cpu(320, 5, 1'b1);
      @(posedge clk); #1;
      drive_cpu(5, 240, 1'b1);
      run_cpu(0);

      // Command held while busy is taken in the first idle cycle
      send_cmd(20, 20, 5, 2, 1'b1);
      send_cmd(40, 40, 3, 3, 1'b0);
      run_cpu(0);

      // Reset in the middle of a fill
      send_cmd(0, 0, 40, 3, 1'b1);
      repeat (10) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      fill_q.delete();
      done_q.delete();
      @(negedge clk);
      chk("midrst_fb_we", fb_we, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      send_cmd(63, 51, 2, 1, 1'b0);
      run_cpu(0);

      // CPU writes while idle, some out of range
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         drive_cpu(int'($urandom_range(339)), int'($urandom_range(255)), 1'($urandom));
      end
      @(posedge clk); #1;
      cpu_wr = 1'b0;

      // Random fills with random CPU interference
      for (int i = 0; i < 20; i++) begin
         x = int'($urandom_range(H - 1));
         y = int'($urandom_range(V - 1));
         w = int'($urandom_range(1, 24));
         h = int'($urandom_range(1, 6));
         if ($urandom_range(4) == 0) w = H - x + int'($urandom_range(0, 2));
         send_cmd(x, y, w, h, 1'($urandom));
         run_cpu(25);
      end

      repeat (4) @(posedge clk);
      chk("end_fill_q_empty", fill_q.size(), 0);
      chk("end_cpu_q_empty", cpu_q.size(), 0);
      chk("end_done_q_empty", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
